// File: rtl/payload_engine_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : payload_engine_ctrl_if
// Description : Bundle of payload input, engine broadcast and result signals
//               for the payload engine sequencer.
//               master = sequencer side, slave = source/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface payload_engine_ctrl_if #(
    parameter int N_ENG = 16
);
    // Payload input stream
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_sop;
    logic             in_eop;
    logic             in_ready;
    // Engine broadcast
    logic [7:0]       eng_data;
    logic             eng_en;
    logic             eng_sod;
    logic [N_ENG-1:0] eng_match;
    // Result channel
    logic [N_ENG-1:0] res_vec;
    logic [15:0]      res_len;
    logic             res_err;
    logic             res_valid;
    logic             res_ready;
    // Discard indication
    logic             drop_pulse;

    modport master (
        input  in_data, in_valid, in_sop, in_eop, eng_match, res_ready,
        output in_ready, eng_data, eng_en, eng_sod,
               res_vec, res_len, res_err, res_valid, drop_pulse
    );

    modport slave (
        output in_data, in_valid, in_sop, in_eop, eng_match, res_ready,
        input  in_ready, eng_data, eng_en, eng_sod,
               res_vec, res_len, res_err, res_valid, drop_pulse
    );
endinterface
`default_nettype wire

// File: rtl/payload_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : payload_engine_ctrl
// Description : Sequences packet bytes into a bank of parallel match engines:
//               clears them at start of packet, broadcasts each byte, pads
//               with flush bytes after the last byte, then captures and holds
//               the engine match vector until the result is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module payload_engine_ctrl #(
    parameter int         N_ENG        = 16,
    parameter int         DRAIN_CYCLES = 2,
    parameter logic [7:0] FLUSH_BYTE   = 8'h0A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    payload_engine_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    // Drain counter: flush bytes while below C_FLUSH_END, one idle cycle for
    // the engines to settle, capture when it reaches C_CAPTURE.
    localparam logic [4:0] C_FLUSH_END = 5'(DRAIN_CYCLES);
    localparam logic [4:0] C_CAPTURE   = 5'(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [7:0]       eng_data_q, eng_data_d;
    logic             eng_en_q, eng_en_d;
    logic             drop_q, drop_d;
    logic [15:0]      len_q, len_d;
    logic             err_q, err_d;
    logic [N_ENG-1:0] vec_q, vec_d;
    logic             valid_q, valid_d;
    logic [4:0]       dcnt_q, dcnt_d;
    logic             w_in_ready;

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        eng_data_d = eng_data_q;
        eng_en_d   = 1'b0;
        drop_d     = 1'b0;
        len_d      = len_q;
        err_d      = err_q;
        vec_d      = vec_q;
        valid_d    = valid_q;
        dcnt_d     = dcnt_q;
        w_in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stray bytes are swallowed; a sop byte is left on the bus
                // and consumed later in RUN.
                w_in_ready = bus.in_valid & ~bus.in_sop;
                drop_d     = bus.in_valid & ~bus.in_sop;
                if (bus.in_valid && bus.in_sop) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                len_d   = 16'd0;
                err_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    eng_data_d = bus.in_data;
                    eng_en_d   = 1'b1;
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                    // A late sop is flagged but the packet carries on.
                    if (bus.in_sop && (len_q != 16'd0)) err_d = 1'b1;
                    if (bus.in_eop) begin
                        state_d = S_DRAIN;
                        dcnt_d  = 5'd0;
                    end
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + 5'd1;
                if (dcnt_q < C_FLUSH_END) begin
                    eng_en_d   = 1'b1;
                    eng_data_d = FLUSH_BYTE;
                end else if (dcnt_q == C_CAPTURE) begin
                    vec_d   = bus.eng_match;
                    valid_d = 1'b1;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_data_q <= 8'd0;
            eng_en_q   <= 1'b0;
            drop_q     <= 1'b0;
            len_q      <= 16'd0;
            err_q      <= 1'b0;
            vec_q      <= '0;
            valid_q    <= 1'b0;
            dcnt_q     <= 5'd0;
        end else begin
            eng_data_q <= eng_data_d;
            eng_en_q   <= eng_en_d;
            drop_q     <= drop_d;
            len_q      <= len_d;
            err_q      <= err_d;
            vec_q      <= vec_d;
            valid_q    <= valid_d;
            dcnt_q     <= dcnt_d;
        end
    end

    // in_ready is gated so it reads 0 while reset is held; eng_sod clears
    // the engines during reset without waiting for a clock.
    assign bus.in_ready   = rst_n & w_in_ready;
    assign bus.eng_sod    = ~rst_n | (state_q == S_CLEAR);
    assign bus.eng_data   = eng_data_q;
    assign bus.eng_en     = eng_en_q;
    assign bus.drop_pulse = drop_q;
    assign bus.res_vec    = vec_q;
    assign bus.res_len    = len_q;
    assign bus.res_err    = err_q;
    assign bus.res_valid  = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_payload_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_payload_engine_ctrl
// Description : Self-checking bench for payload_engine_ctrl: cycle table for a
//               5-byte packet plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_payload_engine_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    payload_engine_ctrl_if #(.N_ENG(16)) bus ();

    payload_engine_ctrl #(
        .N_ENG       (16),
        .DRAIN_CYCLES(2),
        .FLUSH_BYTE  (8'h0A)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine bank stand-in: engine 3 sticks high once it sees byte 0x28.
    always @(posedge clk) begin
        if (bus.eng_sod)                            bus.eng_match <= '0;
        else if (bus.eng_en && bus.eng_data == 8'h28) bus.eng_match[3] <= 1'b1;
    end

    typedef struct {
        logic       valid, sop, eop;
        logic [7:0] data;
        logic       rready;
        logic       x_ready, x_sod, x_en;
        logic [7:0] x_data;
        logic       x_rvalid;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n bytes (sop on byte 0 and on byte sop2), then wait for res_valid
    // with res_ready low. Entered at posedge+1, returns at posedge+2 of the
    // first res_valid cycle.
    task automatic send_pkt(input int n, input int sop2, output int en_cnt,
                            output int sod_cnt, output logic got);
        int   i;
        int   guard;
        logic acc;
        en_cnt = 0; sod_cnt = 0; got = 1'b0; i = 0; guard = 0;
        bus.res_ready = 1'b0;
        while (i < n && guard < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(32'h10 + i);
            bus.in_sop   = (i == 0) || (i == sop2);
            bus.in_eop   = (i == n - 1);
            #1;
            acc = bus.in_ready;
            if (bus.eng_en)  en_cnt++;
            if (bus.eng_sod) sod_cnt++;
            tick();
            if (acc) i++;
            guard++;
        end
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        guard = 0;
        while (!got && guard < 100) begin
            #1;
            if (bus.res_valid) got = 1'b1;
            else begin
                if (bus.eng_en)  en_cnt++;
                if (bus.eng_sod) sod_cnt++;
                tick();
                guard++;
            end
        end
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   en_cnt, sod_cnt, acc_n, bad;
        logic got, acc;

        // 5-byte packet "AB(CD", one row per cycle from the sop offer onward
        tbl[0]  = '{1'b1,1'b1,1'b0,8'h41,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,8'h41,1'b0, 1'b0,1'b1,1'b0,8'h00,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,8'h41,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,8'h42,1'b0, 1'b1,1'b0,1'b1,8'h41,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,8'h28,1'b0, 1'b1,1'b0,1'b1,8'h42,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,8'h43,1'b0, 1'b1,1'b0,1'b1,8'h28,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,8'h44,1'b0, 1'b1,1'b0,1'b1,8'h43,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h44,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h0A,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h0A,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b1};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0};

        // Reset state, with a stray byte offered to prove in_ready is gated
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_data = 8'h55; bus.res_ready = 1'b0; bus.eng_match = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_eng_sod",  32'(bus.eng_sod),  32'd1);
        chk("rst_eng_en",   32'(bus.eng_en),   32'd0);
        chk("rst_res_valid",32'(bus.res_valid),32'd0);
        chk("rst_drop",     32'(bus.drop_pulse),32'd0);
        chk("rst_res_len",  32'(bus.res_len),  32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Table-driven 5-byte packet
        for (int i = 0; i < 13; i++) begin
            bus.in_valid  = tbl[i].valid;
            bus.in_sop    = tbl[i].sop;
            bus.in_eop    = tbl[i].eop;
            bus.in_data   = tbl[i].data;
            bus.res_ready = tbl[i].rready;
            #1;
            chk($sformatf("row%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].x_ready));
            chk($sformatf("row%0d_eng_sod", i),  32'(bus.eng_sod),  32'(tbl[i].x_sod));
            chk($sformatf("row%0d_eng_en", i),   32'(bus.eng_en),   32'(tbl[i].x_en));
            chk($sformatf("row%0d_res_valid", i),32'(bus.res_valid),32'(tbl[i].x_rvalid));
            if (tbl[i].x_en)
                chk($sformatf("row%0d_eng_data", i), 32'(bus.eng_data), 32'(tbl[i].x_data));
            if (tbl[i].x_rvalid) begin
                chk("pkt5_res_vec", 32'(bus.res_vec), 32'h0008);
                chk("pkt5_res_len", 32'(bus.res_len), 32'd5);
                chk("pkt5_res_err", 32'(bus.res_err), 32'd0);
            end
            tick();
        end

        // Three stray bytes in IDLE
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k < 3);
            bus.in_sop   = 1'b0;
            bus.in_data  = 8'(32'h30 + k);
            #1;
            chk($sformatf("stray%0d_in_ready", k), 32'(bus.in_ready), 32'((k < 3) ? 1 : 0));
            chk($sformatf("stray%0d_drop", k), 32'(bus.drop_pulse), 32'((k >= 1 && k <= 3) ? 1 : 0));
            chk($sformatf("stray%0d_eng_en", k), 32'(bus.eng_en), 32'd0);
            chk($sformatf("stray%0d_res_valid", k), 32'(bus.res_valid), 32'd0);
            tick();
        end

        // One-byte packet
        send_pkt(1, -1, en_cnt, sod_cnt, got);
        chk("pkt1_done",    32'(got), 32'd1);
        chk("pkt1_en_cnt",  32'(en_cnt), 32'd3);
        chk("pkt1_sod_cnt", 32'(sod_cnt), 32'd1);
        chk("pkt1_res_len", 32'(bus.res_len), 32'd1);
        chk("pkt1_res_err", 32'(bus.res_err), 32'd0);
        handshake();

        // Six bytes with a second sop on byte 3
        send_pkt(6, 2, en_cnt, sod_cnt, got);
        chk("err_done",    32'(got), 32'd1);
        chk("err_en_cnt",  32'(en_cnt), 32'd8);
        chk("err_sod_cnt", 32'(sod_cnt), 32'd1);
        chk("err_res_len", 32'(bus.res_len), 32'd6);
        chk("err_res_err", 32'(bus.res_err), 32'd1);
        chk("err_res_vec", 32'(bus.res_vec), 32'd0);
        handshake();

        // Result backpressure for 20 cycles while the next packet is offered
        send_pkt(4, -1, en_cnt, sod_cnt, got);
        chk("bp_done", 32'(got), 32'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_eop = 1'b1;
            bus.in_data = 8'h55;
            #1;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_len !== 16'd4 ||
                bus.eng_sod !== 1'b0 || bus.eng_en !== 1'b0) bad++;
        end
        chk("bp_stall_violations", 32'(bad), 32'd0);
        chk("bp_res_len", 32'(bus.res_len), 32'd4);
        handshake();
        #1;
        chk("bp_after_res_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_after_sod_idle",  32'(bus.eng_sod), 32'd0);
        tick();
        chk("bp_next_sod", 32'(bus.eng_sod), 32'd1);
        send_pkt(1, -1, en_cnt, sod_cnt, got);
        chk("bp_next_done", 32'(got), 32'd1);
        chk("bp_next_len",  32'(bus.res_len), 32'd1);
        handshake();

        // Reset pulsed during RUN after four bytes
        acc_n = 0;
        for (int g = 0; g < 20 && acc_n < 4; g++) begin
            bus.in_valid = 1'b1; bus.in_sop = (acc_n == 0); bus.in_eop = 1'b0;
            bus.in_data = 8'(32'h60 + acc_n);
            #1;
            acc = bus.in_ready;
            tick();
            if (acc) acc_n++;
        end
        chk("mid_bytes_sent", 32'(acc_n), 32'd4);
        rst_n = 1'b0;
        bus.in_sop = 1'b0;
        #1;
        chk("mid_rst_sod",       32'(bus.eng_sod), 32'd1);
        chk("mid_rst_en",        32'(bus.eng_en), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("mid_rst_res_len",   32'(bus.res_len), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.res_valid !== 1'b0 || bus.eng_en !== 1'b0) bad++;
            tick();
        end
        chk("mid_no_result", 32'(bad), 32'd0);
        send_pkt(3, -1, en_cnt, sod_cnt, got);
        chk("mid_next_done", 32'(got), 32'd1);
        chk("mid_next_sod",  32'(sod_cnt), 32'd1);
        chk("mid_next_len",  32'(bus.res_len), 32'd3);
        chk("mid_next_err",  32'(bus.res_err), 32'd0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/payload_engine_ctrl.md
PAYLOAD_ENGINE_CTRL -- requirements
Module: payload_engine_ctrl

Interface
REQ-001 Parameter N_ENG, default 16, number of match engines sequenced in parallel (1..64).
REQ-002 Parameter DRAIN_CYCLES, default 2, number of flush bytes driven after the last payload byte (1..15).
REQ-003 Parameter FLUSH_BYTE, default 8'h0A, byte value driven during flush cycles.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  8  payload byte.
REQ-007 in_valid  input  1  in_data qualifier.
REQ-008 in_sop  input  1  first byte of packet.
REQ-009 in_eop  input  1  last byte of packet.
REQ-010 in_ready  output  1  byte accepted when in_valid and in_ready are both high at a rising edge.
REQ-011 eng_data  output  8  registered byte broadcast to the engine character decoders.
REQ-012 eng_en  output  1  registered engine clock enable, one cycle per byte.
REQ-013 eng_sod  output  1  engine clear, active-high.
REQ-014 eng_match  input  N_ENG  sticky match outputs of the engines.
REQ-015 res_vec  output  N_ENG  captured match vector.
REQ-016 res_len  output  16  packet byte count, saturating at 16'hFFFF.
REQ-017 res_err  output  1  packet contained an in_sop after its first byte.
REQ-018 res_valid  output  1  result qualifier.
REQ-019 res_ready  input  1  result accepted when res_valid and res_ready are both high at a rising edge.
REQ-020 drop_pulse  output  1  one-cycle pulse per byte discarded outside a packet.

Function
REQ-021 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN, REPORT.
REQ-022 IDLE: in_ready = in_valid and not in_sop, so stray bytes are consumed, each producing drop_pulse in the following cycle; in_valid and in_sop go to CLEAR without consuming the byte.
REQ-023 CLEAR lasts exactly 1 cycle: eng_sod=1, in_ready=0, byte counter and res_err cleared; then RUN.
REQ-024 RUN: in_ready=1; each accepted byte SHALL appear on eng_data with eng_en=1 in the next cycle; res_len increments per byte, saturating.
REQ-025 RUN: an accepted byte with in_sop=1 and count>0 SHALL set res_err and still be processed as a normal byte, with no restart.
REQ-026 An accepted byte with in_eop=1 SHALL move RUN to DRAIN; a byte with both in_sop and in_eop is a valid 1-byte packet.
REQ-027 Eop byte accepted at edge E0: eng_en=1 with that byte in cycle 1, FLUSH_BYTE with eng_en=1 in cycles 2..DRAIN_CYCLES+1, eng_en=0 from cycle DRAIN_CYCLES+2.
REQ-028 res_vec SHALL be captured from eng_match at edge E(DRAIN_CYCLES+2); REPORT is entered at that edge and res_valid=1 from the following cycle.
REQ-029 REPORT: in_ready=0 and eng_en=0; res_vec, res_len and res_err held stable until res_ready; on handshake res_valid drops next cycle and FSM returns to IDLE.
REQ-030 Backpressure: res_ready low indefinitely SHALL stall input with no byte loss; eng_match is not disturbed, because eng_en=0 and eng_sod=0.
REQ-031 eng_sod SHALL be 0 in all states except CLEAR and reset.
REQ-032 eng_en SHALL be 0 in IDLE, CLEAR and REPORT, and in RUN cycles following no accepted byte.

Reset
REQ-033 While rst_n=0: eng_sod=1 combinationally; all other outputs 0; FSM IDLE; counters 0.
REQ-034 Reset asserted mid-packet SHALL abort it with no result issued; after release the FSM waits in IDLE for a new in_sop.
REQ-035 First rising edge after rst_n release SHALL behave as IDLE.

Verification
REQ-036 5-byte packet "AB\x28CD" with engine 3 matching, res_ready=1 -> eng_sod one cycle, 5 eng_en pulses with the same bytes, 2 flush 0x0A, res_vec=16'h0008, res_len=5, res_err=0, res_valid 5 cycles after eop.
REQ-037 1-byte packet (sop and eop together) -> CLEAR, 1 data plus 2 flush eng_en cycles, res_len=1.
REQ-038 res_ready held 0 for 20 cycles while next packet is offered -> in_ready=0 throughout, result stable, next packet starts with eng_sod after the handshake.
REQ-039 3 bytes without in_sop in IDLE -> 3 drop_pulse, no eng_en, no result.
REQ-040 Packet with in_sop on byte 3 -> single result, res_err=1, res_len equals total bytes.
REQ-041 rst_n pulsed low during RUN after 4 bytes -> eng_sod=1 during reset, no res_valid, next packet reports res_len counted from its own sop only.
